// File: rtl/red_pitaya_mux_seq.sv
// ----------------------------------------------------------------------------
// red_pitaya_mux_seq
//
// Sequencer for an external analog multiplexer in front of the ADC. It walks
// the mux address over a set of enabled channels. After each address change
// it blanks the samples for a settling interval. It then flags the samples as
// valid for a dwell interval before it moves on.
//
// Operating modes (mode_i):
//   0 : continuous round-robin scan over the enabled channels
//   1 : hold a single fixed channel (fixed_ch_i)
//   2 : one sweep from the lowest to the highest enabled channel per start_i
//   3 : behaves as mode 0
//
// Parameters:
//   CHNL : number of mux channels (2..16)
//   AW   : mux address width, CHNL <= 2**AW
//   CW   : width of the settle/dwell down-counter
//
// Ports:
//   adc_clk_i         in   ADC clock, all logic on the rising edge
//   adc_rstn_i        in   synchronous reset, active HIGH despite the name
//   active_channels_i in   [CHNL] channel enable mask, bit n enables address n
//   mode_i            in   [2]    operating mode
//   fixed_ch_i        in   [AW]   channel used in hold mode (clamped to 0 if >= CHNL)
//   start_i           in   single-cycle pulse that starts a sweep in mode 2
//   settle_i          in   [CW]   blanking cycles after every address change
//   dwell_i           in   [CW]   valid cycles per channel visit (0 acts as 1)
//   mux_addr_o        out  [AW]   registered mux address
//   sample_valid_o    out  high while the current address is settled and dwelling
//   chan_o            out  [AW]   channel tag of the current samples
//   switch_o          out  one-cycle pulse in the cycle mux_addr_o changes
//   sweep_done_o      out  one-cycle pulse after the last channel of a sweep
//   busy_o            out  high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module red_pitaya_mux_seq #(
    parameter int CHNL = 8,
    parameter int AW   = 3,
    parameter int CW   = 16
) (
    input  logic            adc_clk_i,
    input  logic            adc_rstn_i,
    input  logic [CHNL-1:0] active_channels_i,
    input  logic [1:0]      mode_i,
    input  logic [AW-1:0]   fixed_ch_i,
    input  logic            start_i,
    input  logic [CW-1:0]   settle_i,
    input  logic [CW-1:0]   dwell_i,
    output logic [AW-1:0]   mux_addr_o,
    output logic            sample_valid_o,
    output logic [AW-1:0]   chan_o,
    output logic            switch_o,
    output logic            sweep_done_o,
    output logic            busy_o
);

    // The mask is padded to the full address space. Any AW-bit index is then
    // in range, and the padding bits are always zero.
    localparam int MW = 2 ** AW;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DWELL  = 2'd2;

    localparam logic [1:0] MODE_SCAN  = 2'd0;
    localparam logic [1:0] MODE_HOLD  = 2'd1;
    localparam logic [1:0] MODE_SWEEP = 2'd2;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]    state;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
    logic          switch_q;
    logic          done_q;
    logic [1:0]    run_mode;

    logic [1:0]    state_n;
    logic [AW-1:0] addr_n;
    logic [CW-1:0] cnt_n;
    logic          switch_n;
    logic          done_n;
    logic [1:0]    run_mode_n;

    // ------------------------------------------------------------------
    // Decoded inputs
    // ------------------------------------------------------------------
    logic [MW-1:0] mask_pad;
    logic          mask_zero;
    logic [1:0]    mode_eff;
    logic [AW-1:0] fixed_clamped;
    logic [CW-1:0] dwell_eff;

    assign mask_pad      = MW'(active_channels_i);
    assign mask_zero     = (active_channels_i == '0);
    assign mode_eff      = (mode_i == 2'd3) ? MODE_SCAN : mode_i;
    assign fixed_clamped = (int'(fixed_ch_i) >= CHNL) ? '0 : fixed_ch_i;
    assign dwell_eff     = (dwell_i == '0) ? CW'(1) : dwell_i;

    // ------------------------------------------------------------------
    // Round-robin search. Candidates are from+1, from+2, ... and the search
    // wraps at CHNL-1. The last candidate is 'from' itself. The MSB of the
    // result tells whether the winner was reached only after wrapping. Sweep
    // mode uses that bit to detect the end of a pass.
    // ------------------------------------------------------------------
    function automatic logic [AW:0] rr_search(input logic [AW-1:0] from,
                                              input logic [MW-1:0] mask);
        logic          found;
        logic [AW:0]   res;
        int            pos;
        found = 1'b0;
        res   = '0;
        for (int i = 1; i <= CHNL; i++) begin
            pos = int'(from) + i;
            if (!found) begin
                if (pos >= CHNL) begin
                    if (mask[AW'(pos - CHNL)]) begin
                        found = 1'b1;
                        res   = {1'b1, AW'(pos - CHNL)};
                    end
                end else if (mask[AW'(pos)]) begin
                    found = 1'b1;
                    res   = {1'b0, AW'(pos)};
                end
            end
        end
        return res;
    endfunction

    logic [AW:0]   scan_res;
    logic [AW:0]   sweep_res;
    logic [AW-1:0] scan_next;
    logic          scan_wrap;
    logic [AW-1:0] sweep_first;

    // A search that starts at CHNL-1 wraps straight to 0. It therefore finds
    // the lowest enabled channel, which is where a sweep begins.
    assign scan_res    = rr_search(addr, mask_pad);
    assign sweep_res   = rr_search(AW'(CHNL - 1), mask_pad);
    assign scan_next   = scan_res[AW-1:0];
    assign scan_wrap   = scan_res[AW];
    assign sweep_first = sweep_res[AW-1:0];

    // ------------------------------------------------------------------
    // Next-state logic.
    // 'go' requests a move to 'target'. The address is loaded, switch_o
    // pulses if the address really changes, and the settle interval starts.
    // With a zero settle the move goes straight to DWELL. Mask and mode are
    // only consulted in IDLE and at the end of a dwell. The one exception is
    // the all-zero mask abort at the bottom, which has the last word.
    // ------------------------------------------------------------------
    logic          go;
    logic [AW-1:0] target;

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        cnt_n      = cnt;
        switch_n   = 1'b0;
        done_n     = 1'b0;
        run_mode_n = run_mode;
        go         = 1'b0;
        target     = addr;

        case (state)
            ST_IDLE: begin
                run_mode_n = mode_eff;
                case (mode_eff)
                    MODE_SCAN: begin
                        if (!mask_zero) begin
                            go     = 1'b1;
                            target = scan_next;
                        end
                    end
                    MODE_HOLD: begin
                        go     = 1'b1;
                        target = fixed_clamped;
                    end
                    default: begin
                        if (start_i && !mask_zero) begin
                            go     = 1'b1;
                            target = sweep_first;
                        end
                    end
                endcase
            end

            ST_SETTLE: begin
                if (cnt <= CW'(1)) begin
                    state_n = ST_DWELL;
                    cnt_n   = dwell_eff;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            ST_DWELL: begin
                if (cnt <= CW'(1)) begin
                    run_mode_n = mode_eff;
                    case (mode_eff)
                        MODE_SCAN: begin
                            if (scan_next == addr) begin
                                cnt_n = dwell_eff;
                            end else begin
                                go     = 1'b1;
                                target = scan_next;
                            end
                        end
                        MODE_HOLD: begin
                            if (fixed_clamped == addr) begin
                                cnt_n = dwell_eff;
                            end else begin
                                go     = 1'b1;
                                target = fixed_clamped;
                            end
                        end
                        default: begin
                            if (scan_wrap) begin
                                state_n = ST_IDLE;
                                cnt_n   = '0;
                                done_n  = 1'b1;
                            end else begin
                                go     = 1'b1;
                                target = scan_next;
                            end
                        end
                    endcase
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (go) begin
            addr_n   = target;
            switch_n = (target != addr);
            if (settle_i == '0) begin
                state_n = ST_DWELL;
                cnt_n   = dwell_eff;
            end else begin
                state_n = ST_SETTLE;
                cnt_n   = settle_i;
            end
        end

        // An empty mask stops a scan or sweep at once. The address is held.
        if (state != ST_IDLE && run_mode != MODE_HOLD && mask_zero) begin
            state_n  = ST_IDLE;
            addr_n   = addr;
            cnt_n    = '0;
            switch_n = 1'b0;
            done_n   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers with synchronous reset.
    // ------------------------------------------------------------------
    always_ff @(posedge adc_clk_i) begin
        if (adc_rstn_i) begin
            state    <= ST_IDLE;
            addr     <= '0;
            cnt      <= '0;
            switch_q <= 1'b0;
            done_q   <= 1'b0;
            run_mode <= MODE_SCAN;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            cnt      <= cnt_n;
            switch_q <= switch_n;
            done_q   <= done_n;
            run_mode <= run_mode_n;
        end
    end

    assign mux_addr_o     = addr;
    assign chan_o         = addr;
    assign sample_valid_o = (state == ST_DWELL);
    assign switch_o       = switch_q;
    assign sweep_done_o   = done_q;
    assign busy_o         = (state != ST_IDLE);

endmodule

// File: tb/tb_red_pitaya_mux_seq.sv
// ----------------------------------------------------------------------------
// tb_red_pitaya_mux_seq
//
// Directed bench for red_pitaya_mux_seq with the default parameters
// (CHNL=8, AW=3, CW=16). Each scenario queues the output pattern it expects,
// one entry per clock. The queue is then drained and each entry is compared
// with the DUT outputs sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_red_pitaya_mux_seq;

    typedef struct packed {
        logic [2:0] addr;
        logic [2:0] chan;
        logic       valid;
        logic       sw;
        logic       done;
        logic       busy;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [7:0]  mask;
    logic [1:0]  mode;
    logic [2:0]  fixed_ch;
    logic        start;
    logic [15:0] settle;
    logic [15:0] dwell;
    logic [2:0]  mux_addr;
    logic        sample_valid;
    logic [2:0]  chan;
    logic        switch_p;
    logic        sweep_done;
    logic        busy;

    obs_t        sb[$];
    int          n_pass;
    int          n_fail;

    red_pitaya_mux_seq #(.CHNL(8), .AW(3), .CW(16)) dut (
        .adc_clk_i        (clk),
        .adc_rstn_i       (rst),
        .active_channels_i(mask),
        .mode_i           (mode),
        .fixed_ch_i       (fixed_ch),
        .start_i          (start),
        .settle_i         (settle),
        .dwell_i          (dwell),
        .mux_addr_o       (mux_addr),
        .sample_valid_o   (sample_valid),
        .chan_o           (chan),
        .switch_o         (switch_p),
        .sweep_done_o     (sweep_done),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] m, input logic [1:0] md,
                                 input logic [2:0] fc, input int s, input int d);
        mask     = m;
        mode     = md;
        fixed_ch = fc;
        settle   = 16'(s);
        dwell    = 16'(d);
    endtask

    task automatic expect_out(input logic [2:0] a, input logic v, input logic s,
                              input logic d, input logic b);
        obs_t e;
        e.addr  = a;
        e.chan  = a;
        e.valid = v;
        e.sw    = s;
        e.done  = d;
        e.busy  = b;
        sb.push_back(e);
    endtask

    // One visit of a channel: the settle cycles (the switch pulse rides on
    // the first one), then the valid dwell cycles.
    task automatic visit(input logic [2:0] ch, input int s, input int d, input logic sw);
        int dd;
        dd = (d == 0) ? 1 : d;
        for (int i = 0; i < s; i++) expect_out(ch, 1'b0, (i == 0) ? sw : 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < dd; i++) expect_out(ch, 1'b1, (s == 0 && i == 0) ? sw : 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string tag);
        obs_t act;
        obs_t exp_v;
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        act   = '{addr: mux_addr, chan: chan, valid: sample_valid, sw: switch_p,
                  done: sweep_done, busy: busy};
        assert (act === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed addr/chan/valid/sw/done/busy=%h/%h/%b/%b/%b/%b expected %h/%h/%b/%b/%b/%b",
                   tag, act.addr, act.chan, act.valid, act.sw, act.done, act.busy,
                   exp_v.addr, exp_v.chan, exp_v.valid, exp_v.sw, exp_v.done, exp_v.busy);
        end
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) checkOutput(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        expect_out(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset");
        rst = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        applyStimulus(8'h00, 2'd0, 3'd0, 0, 0);

        // Reset state
        expect_out(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("reset_state");

        // Continuous scan over channels 0, 2 and 5
        $display("[TB] scan mask 0x25 settle 3 dwell 5");
        applyStimulus(8'h25, 2'd0, 3'd0, 3, 5);
        rst = 1'b0;
        visit(3'd2, 3, 5, 1'b1);
        visit(3'd5, 3, 5, 1'b1);
        visit(3'd0, 3, 5, 1'b1);
        visit(3'd2, 3, 5, 1'b1);
        drain("scan_rr");

        // Single enabled channel: one settle, then continuous dwell.
        // settle_i changes mid-settle and must not stretch the interval.
        $display("[TB] scan single channel 3");
        do_reset();
        applyStimulus(8'h08, 2'd0, 3'd0, 4, 2);
        visit(3'd3, 4, 2, 1'b1);
        for (int i = 0; i < 6; i++) expect_out(3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("single_settle");
        checkOutput("single_settle");
        settle = 16'd9;
        drain("single_hold");

        // Hold mode: fixed channel 6, changed to 2 mid-dwell. The empty mask
        // does not matter here.
        $display("[TB] hold 6 then 2");
        do_reset();
        applyStimulus(8'h00, 2'd1, 3'd6, 2, 4);
        visit(3'd6, 2, 4, 1'b1);
        visit(3'd2, 2, 4, 1'b1);
        for (int i = 0; i < 3; i++) expect_out(3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) checkOutput("hold_6");
        fixed_ch = 3'd2;
        drain("hold_2");

        // Sweep mode over channels 1 and 7
        $display("[TB] sweep mask 0x82");
        do_reset();
        applyStimulus(8'h82, 2'd2, 3'd0, 1, 2);
        expect_out(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("sweep_wait");
        visit(3'd1, 1, 2, 1'b1);
        visit(3'd7, 1, 2, 1'b1);
        expect_out(3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        checkOutput("sweep1");
        start = 1'b0;
        checkOutput("sweep1");
        start = 1'b1;
        checkOutput("sweep1_busy_start");
        start = 1'b0;
        drain("sweep1");
        visit(3'd1, 1, 2, 1'b1);
        visit(3'd7, 1, 2, 1'b1);
        expect_out(3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        checkOutput("sweep2");
        start = 1'b0;
        drain("sweep2");

        // Zero settle/dwell gives one valid cycle per channel. Then the mask
        // is cleared mid-dwell.
        $display("[TB] zero settle/dwell then mask clear");
        do_reset();
        applyStimulus(8'h25, 2'd0, 3'd0, 0, 0);
        expect_out(3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_out(3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_out(3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_out(3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("zero_dwell");
        dwell = 16'd4;
        expect_out(3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_out(3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("dwell4");
        mask = 8'h00;
        expect_out(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("mask_clear");

        // Reset mid-settle at address 5. Mode 3 acts as a scan.
        $display("[TB] reset mid-settle, mode 3");
        do_reset();
        applyStimulus(8'h25, 2'd3, 3'd0, 3, 2);
        visit(3'd2, 3, 2, 1'b1);
        expect_out(3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_out(3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("pre_reset");
        do_reset();
        visit(3'd2, 3, 2, 1'b1);
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
